// File: rtl/aes_round_sequencer_if.sv
// Block-level valid/ready bus for the iterative AES-128 round sequencer.
// The slave side is the sequencer; the master side is the producer/consumer.
interface aes_round_sequencer_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [3:0]   round_idx;

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data, busy, round_idx
  );

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data, busy, round_idx
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryptor: one shared round datapath applied once per clock,
// with the round-key schedule derived combinationally from a held key register.
module aes_round_sequencer #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input logic                   clk,
  input logic                   rst_n,
  aes_round_sequencer_if.slave  bus
);

  localparam int unsigned BLK_W    = 128;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned NUM_KEYS = 11;
  localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(NUM_ROUNDS);
  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // GF(2^8) multiply by x, reduced by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as inverse (x^254, zero maps to zero) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [BLK_W-1:0] sub_bytes(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    end
    return o;
  endfunction

  // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
  function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // One step of the AES-128 key schedule: next round key from the previous one.
  function automatic logic [BLK_W-1:0] key_step(input logic [BLK_W-1:0] k,
                                                input logic [7:0]       rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
         ^ {rc, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_e             state_q, state_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic [BLK_W-1:0]   key_q, key_d;
  logic [IDX_W-1:0]   round_idx_q, round_idx_d;
  logic               out_valid_q, out_valid_d;
  logic [BLK_W-1:0]   out_data_q, out_data_d;
  logic               busy_q, busy_d;

  logic               in_ready_c;
  logic               last_round_c;
  logic [BLK_W-1:0]   rk_c [NUM_KEYS];
  logic [BLK_W-1:0]   round_key_c;
  logic [BLK_W-1:0]   sub_c, shf_c, mix_c, round_out_c;

  // Round-key schedule, combinational from the held key.
  always_comb begin
    rk_c[0] = key_q;
    for (int r = 1; r < NUM_KEYS; r++) begin
      rk_c[r] = key_step(rk_c[r-1], RCON[r-1]);
    end
  end

  // Shared round datapath; the final round skips mix_columns.
  always_comb begin
    last_round_c = (round_idx_q == LAST_ROUND);
    round_key_c  = rk_c[round_idx_q];
    sub_c        = sub_bytes(blk_q);
    shf_c        = shift_rows(sub_c);
    mix_c        = last_round_c ? shf_c : mix_columns(shf_c);
    round_out_c  = mix_c ^ round_key_c;
  end

  // in_ready only follows out_ready while a result is waiting.
  always_comb begin
    in_ready_c = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
  end

  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    key_d       = key_q;
    round_idx_d = round_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          key_d       = bus.in_key;
          blk_d       = bus.in_data ^ bus.in_key;
          round_idx_d = IDX_W'(1);
          busy_d      = 1'b1;
          state_d     = S_ROUND;
        end
      end
      S_ROUND: begin
        blk_d = round_out_c;
        if (last_round_c) begin
          out_data_d  = round_out_c;
          out_valid_d = 1'b1;
          round_idx_d = '0;
          busy_d      = 1'b0;
          state_d     = S_DONE;
        end else begin
          round_idx_d = round_idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (bus.in_valid) begin
            key_d       = bus.in_key;
            blk_d       = bus.in_data ^ bus.in_key;
            round_idx_d = IDX_W'(1);
            busy_d      = 1'b1;
            state_d     = S_ROUND;
          end else begin
            state_d     = S_IDLE;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        round_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      blk_q       <= '0;
      key_q       <= '0;
      round_idx_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      key_q       <= key_d;
      round_idx_q <= round_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;
  assign bus.round_idx = round_idx_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: FIPS-197 vectors, handshake scenarios and
// random blocks checked against a byte-array AES-128 model.
module tb_aes_round_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [7:0] sb [256];

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_round_sequencer_if bus ();

  aes_round_sequencer #(.NUM_ROUNDS(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // S-box generated by walking powers of 3 and their inverses.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    logic hi;
    p = 8'h01;
    q = 8'h01;
    for (int i = 0; i < 255; i++) begin
      hi = p[7];
      p = p ^ 8'(p << 1) ^ (hi ? 8'h1b : 8'h00);
      q = q ^ 8'(q << 1);
      q = q ^ 8'(q << 2);
      q = q ^ 8'(q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end
    sb[0] = 8'h63;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return 8'(a << 1) ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt,
                                                 input logic [127:0] key,
                                                 input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] k [176];
    logic [7:0] tmp [4];
    logic [7:0] rot [4];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = k[i-4+j];
      if (i % 16 == 0) begin
        for (int j = 0; j < 4; j++) rot[j] = sb[tmp[(j+1)%4]];
        for (int j = 0; j < 4; j++) tmp[j] = rot[j];
        tmp[0] = tmp[0] ^ rc;
        rc = xt(rc);
      end
      for (int j = 0; j < 4; j++) k[i+j] = k[i-16+j] ^ tmp[j];
    end
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r+4*c] = t[r+4*((c+r)%4)];
      if (rnd != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[16*rnd+i];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until out_valid is seen or the budget of edges runs out.
  task automatic wait_valid(input int budget, output int edges);
    edges = 0;
    while (bus.out_valid !== 1'b1 && edges < budget) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_model();
    logic [127:0] m;
    m = model_encrypt(PT_B, KEY_B, 10);
    total++;
    if (m !== CT_B) begin bad++; $display("FAIL model_b got=%h exp=%h", m, CT_B); end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_key = '0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.round_idx} !== 7'b1_0_0_0000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=%b",
               {bus.in_ready, bus.out_valid, bus.busy, bus.round_idx}, 7'b1_0_0_0000);
    end
    total++;
    if (bus.out_data !== 128'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", bus.out_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fips_b();
    bus.in_data = PT_B; bus.in_key = KEY_B; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    total++;
    if ({bus.busy, bus.round_idx, bus.in_ready, bus.out_valid} !== {1'b1, 4'd1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL fipsb_accept got=%b exp=%b",
               {bus.busy, bus.round_idx, bus.in_ready, bus.out_valid}, {1'b1, 4'd1, 1'b0, 1'b0});
    end
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e < 10) begin
        total++;
        if (bus.round_idx !== 4'(e + 1) || bus.out_valid !== 1'b0) begin
          bad++;
          $display("FAIL fipsb_round e=%0d got idx=%0d valid=%b exp idx=%0d valid=0",
                   e, bus.round_idx, bus.out_valid, e + 1);
        end
      end
    end
    total++;
    if ({bus.out_valid, bus.round_idx, bus.busy} !== {1'b1, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL fipsb_latency got=%b exp=%b", {bus.out_valid, bus.round_idx, bus.busy}, 6'b1_0000_0);
    end
    total++;
    if (bus.out_data !== CT_B) begin bad++; $display("FAIL fipsb_data got=%h exp=%h", bus.out_data, CT_B); end
    tick();
    total++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin
      bad++;
      $display("FAIL fipsb_drain got=%b exp=010", {bus.out_valid, bus.in_ready, bus.busy});
    end
  endtask

  task automatic test_fips_c1();
    int edges;
    bus.in_data = PT_C; bus.in_key = KEY_C; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_valid(40, edges);
    total++;
    if (bus.out_valid !== 1'b1 || edges != 10) begin
      bad++;
      $display("FAIL fipsc_latency got valid=%b edges=%0d exp valid=1 edges=10", bus.out_valid, edges);
    end
    total++;
    if (bus.out_data !== CT_C) begin bad++; $display("FAIL fipsc_data got=%h exp=%h", bus.out_data, CT_C); end
    tick();
  endtask

  task automatic test_backpressure();
    int edges;
    bus.in_data = PT_B; bus.in_key = KEY_B; bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_valid(40, edges);
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
      bus.in_key   = {$urandom, $urandom, $urandom, $urandom};
      tick();
      total++;
      if (bus.out_data !== CT_B || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold i=%0d got data=%h valid=%b ready=%b exp data=%h valid=1 ready=0",
                 i, bus.out_data, bus.out_valid, bus.in_ready, CT_B);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_follow got=%b exp=1", bus.in_ready); end
    tick();
    total++;
    if ({bus.out_valid, bus.busy, bus.round_idx, bus.in_ready} !== 7'b0_0_0000_1) begin
      bad++;
      $display("FAIL bp_release got=%b exp=%b",
               {bus.out_valid, bus.busy, bus.round_idx, bus.in_ready}, 7'b0_0_0000_1);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    bus.out_ready = 1'b1;
    bus.in_data = PT_B; bus.in_key = KEY_B; bus.in_valid = 1'b1;
    tick();
    bus.in_data = PT_C; bus.in_key = KEY_C;
    wait_valid(40, edges);
    total++;
    if (bus.out_data !== CT_B || edges != 10) begin
      bad++;
      $display("FAIL b2b_first got=%h edges=%0d exp=%h edges=10", bus.out_data, edges, CT_B);
    end
    tick();
    bus.in_valid = 1'b0;
    total++;
    if ({bus.out_valid, bus.busy, bus.round_idx} !== {1'b0, 1'b1, 4'd1}) begin
      bad++;
      $display("FAIL b2b_reaccept got=%b exp=%b", {bus.out_valid, bus.busy, bus.round_idx}, 6'b0_1_0001);
    end
    wait_valid(40, edges);
    total++;
    if (bus.out_data !== CT_C || edges != 10) begin
      bad++;
      $display("FAIL b2b_second got=%h edges=%0d exp=%h edges=10", bus.out_data, edges, CT_C);
    end
    tick();
  endtask

  task automatic test_input_change();
    int edges;
    bus.in_data = PT_B; bus.in_key = KEY_B; bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    tick();
    edges = 0;
    while (bus.out_valid !== 1'b1 && edges < 40) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
      bus.in_key   = {$urandom, $urandom, $urandom, $urandom};
      tick();
      edges++;
    end
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== CT_B) begin
      bad++;
      $display("FAIL inchg_data got valid=%b data=%h exp valid=1 data=%h", bus.out_valid, bus.out_data, CT_B);
    end
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    int edges;
    bus.in_data = PT_B; bus.in_key = KEY_B; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    total++;
    if (bus.round_idx !== 4'd5) begin bad++; $display("FAIL arst_pre got=%0d exp=5", bus.round_idx); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.round_idx} !== 7'b1_0_0_0000 || bus.out_data !== '0) begin
      bad++;
      $display("FAIL arst_immediate got=%b data=%h exp=%b data=0",
               {bus.in_ready, bus.out_valid, bus.busy, bus.round_idx}, bus.out_data, 7'b1_0_0_0000);
    end
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b exp=1", bus.in_ready); end
    edges = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) edges++;
    end
    total++;
    if (edges != 0) begin bad++; $display("FAIL arst_spurious got=%0d valid cycles exp=0", edges); end
    bus.in_data = PT_C; bus.in_key = KEY_C; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_valid(40, edges);
    total++;
    if (bus.out_data !== CT_C || edges != 10) begin
      bad++;
      $display("FAIL arst_fresh got=%h edges=%0d exp=%h edges=10", bus.out_data, edges, CT_C);
    end
    tick();
  endtask

  task automatic test_random();
    logic [127:0] pt, key, exp_ct;
    int edges;
    int hold;
    for (int n = 0; n < 8; n++) begin
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      exp_ct = model_encrypt(pt, key, 10);
      bus.in_data = pt; bus.in_key = key; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      bus.in_data = ~pt; bus.in_key = ~key;
      wait_valid(40, edges);
      hold = $urandom_range(0, 3);
      repeat (hold) tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_ct || edges != 10) begin
        bad++;
        $display("FAIL rand n=%0d got valid=%b data=%h edges=%0d exp valid=1 data=%h edges=10",
                 n, bus.out_valid, bus.out_data, edges, exp_ct);
      end
      bus.out_ready = 1'b1;
      tick();
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL rand_drain n=%0d got valid=%b ready=%b exp valid=0 ready=1",
                 n, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  initial begin
    build_sbox();
    test_model();
    test_reset();
    test_fips_b();
    test_fips_c1();
    test_backpressure();
    test_back_to_back();
    test_input_change();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
